// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset control path.
// Also used by the single-cycle ALU_Control, so keep encodings stable.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRA = 4'd6;
    localparam logic [3:0] ALU_MUL = 4'd7;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

    localparam logic WB_ALUOUT = 1'b0;
    localparam logic WB_MDR    = 1'b1;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    // Dispatch target after DECODE; unknown opcodes fall into the trap.
    function automatic state_t nextFromOpcode(input logic [6:0] opcode);
        state_t s;
        case (opcode)
            OP_R:               s = S_EXEC_R;
            OP_IMM:             s = S_EXEC_I;
            OP_LOAD, OP_STORE:  s = S_MEM_ADDR;
            OP_BRANCH:          s = S_BRANCH;
            default:            s = S_TRAP;
        endcase
        return s;
    endfunction

    function automatic logic isBusyState(input state_t s);
        return (s != S_IDLE) && (s != S_TRAP);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the current control state and instruction fields to an ALU operation
// plus a legality flag that the sequencer uses to divert into TRAP.
module alu_decoder
    import cpu_pkg::*;
(
    input  state_t     state_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_ctrl_o,
    output logic       legal_o
);

    logic [9:0] w_funct;

    assign w_funct = {funct7_i, funct3_i};

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        legal_o    = 1'b1;
        case (state_i)
            S_EXEC_R: begin
                case (w_funct)
                    {7'b0000000, 3'b000}: alu_ctrl_o = ALU_ADD;
                    {7'b0100000, 3'b000}: alu_ctrl_o = ALU_SUB;
                    {7'b0000000, 3'b111}: alu_ctrl_o = ALU_AND;
                    {7'b0000000, 3'b110}: alu_ctrl_o = ALU_OR;
                    {7'b0000000, 3'b100}: alu_ctrl_o = ALU_XOR;
                    {7'b0000000, 3'b001}: alu_ctrl_o = ALU_SLL;
                    {7'b0000001, 3'b000}: alu_ctrl_o = ALU_MUL;
                    default:              legal_o    = 1'b0;
                endcase
            end
            S_EXEC_I: begin
                if (funct3_i == 3'b000) begin
                    alu_ctrl_o = ALU_ADD;
                end else if (funct3_i == 3'b101 && funct7_i == 7'b0100000) begin
                    alu_ctrl_o = ALU_SRA;
                end else begin
                    legal_o = 1'b0;
                end
            end
            S_MEM_ADDR: begin
                legal_o = ((opcode_i == OP_LOAD) || (opcode_i == OP_STORE))
                          && (funct3_i == F3_WORD);
            end
            // Branch compare is a subtract; only beq is supported.
            S_BRANCH: begin
                alu_ctrl_o = ALU_SUB;
                legal_o    = (funct3_i == F3_BEQ);
            end
            default: begin
                alu_ctrl_o = ALU_ADD;
                legal_o    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM sequencing a multi-cycle RV32I-subset datapath:
// fetch/decode/execute/memory/writeback, retire counting and illegal-op trap.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [6:0]       opcode_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             ir_write_o,
    output logic             reg_write_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [3:0]       alu_ctrl_o,
    output logic [1:0]       imm_sel_o,
    output logic             wb_sel_o,
    output logic             busy_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] retired_o
);

    state_t           r_state;
    state_t           w_nextState;
    logic             w_retire;
    logic [3:0]       w_aluCtrl;
    logic             w_legal;
    logic [CNT_W-1:0] r_retired;
    logic             r_illegal;

    alu_decoder u_aluDecoder (
        .state_i    (r_state),
        .opcode_i   (opcode_i),
        .funct3_i   (funct3_i),
        .funct7_i   (funct7_i),
        .alu_ctrl_o (w_aluCtrl),
        .legal_o    (w_legal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Instruction completion is a transition, not a state: it retires and
    // either chains straight into the next fetch or parks in IDLE.
    always_comb begin
        w_nextState = r_state;
        w_retire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_nextState = S_FETCH;
                end
            end
            S_FETCH:  w_nextState = S_DECODE;
            S_DECODE: w_nextState = nextFromOpcode(opcode_i);
            S_EXEC_R, S_EXEC_I: begin
                w_nextState = w_legal ? S_WB_ALU : S_TRAP;
            end
            S_MEM_ADDR: begin
                if (!w_legal) begin
                    w_nextState = S_TRAP;
                end else if (opcode_i == OP_STORE) begin
                    w_nextState = S_MEM_WR;
                end else begin
                    w_nextState = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (mem_ready_i) begin
                    w_nextState = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    w_retire = 1'b1;
                end
            end
            S_WB_ALU, S_WB_MEM: w_retire = 1'b1;
            S_BRANCH: begin
                if (w_legal) begin
                    w_retire = 1'b1;
                end else begin
                    w_nextState = S_TRAP;
                end
            end
            S_TRAP:  w_nextState = S_TRAP;
            default: w_nextState = S_IDLE;
        endcase
        if (w_retire) begin
            w_nextState = start_i ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_nextState == S_TRAP) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Only BRANCH's pc_write and the field-dependent ALU/imm selects look
    // past the state register.
    always_comb begin
        pc_write_o  = 1'b0;
        pc_src_o    = PC_SRC_ALU;
        ir_write_o  = 1'b0;
        reg_write_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        alu_src_a_o = SRC_A_PC;
        alu_src_b_o = SRC_B_RS2;
        alu_ctrl_o  = ALU_ADD;
        imm_sel_o   = IMM_I;
        wb_sel_o    = WB_ALUOUT;
        busy_o      = isBusyState(r_state);
        case (r_state)
            S_FETCH: begin
                ir_write_o  = 1'b1;
                pc_write_o  = 1'b1;
                pc_src_o    = PC_SRC_ALU;
                alu_src_a_o = SRC_A_PC;
                alu_src_b_o = SRC_B_FOUR;
            end
            S_DECODE: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
                imm_sel_o   = IMM_B;
            end
            S_EXEC_R: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_RS2;
                alu_ctrl_o  = w_aluCtrl;
            end
            S_EXEC_I: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                imm_sel_o   = IMM_I;
                alu_ctrl_o  = w_aluCtrl;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                imm_sel_o   = (opcode_i == OP_STORE) ? IMM_S : IMM_I;
                alu_ctrl_o  = w_aluCtrl;
            end
            S_MEM_RD: mem_read_o  = 1'b1;
            S_MEM_WR: mem_write_o = 1'b1;
            S_WB_ALU: begin
                reg_write_o = 1'b1;
                wb_sel_o    = WB_ALUOUT;
            end
            S_WB_MEM: begin
                reg_write_o = 1'b1;
                wb_sel_o    = WB_MDR;
            end
            S_BRANCH: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_RS2;
                alu_ctrl_o  = w_aluCtrl;
                pc_src_o    = PC_SRC_ALUOUT;
                pc_write_o  = zero_i;
            end
            default: begin
                pc_write_o = 1'b0;
            end
        endcase
    end

    assign illegal_o = r_illegal;
    assign retired_o = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: each instruction vector is
// queued on issue and compared against what the FSM did once it goes idle.
module tb_multicycle_control;

    localparam int CNT_W = 32;

    logic             clk_i;
    logic             rst_i;
    logic             start_i;
    logic [6:0]       opcode_i;
    logic [2:0]       funct3_i;
    logic [6:0]       funct7_i;
    logic             zero_i;
    logic             mem_ready_i;
    logic             pc_write_o;
    logic             pc_src_o;
    logic             ir_write_o;
    logic             reg_write_o;
    logic             mem_read_o;
    logic             mem_write_o;
    logic [1:0]       alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic [3:0]       alu_ctrl_o;
    logic [1:0]       imm_sel_o;
    logic             wb_sel_o;
    logic             busy_o;
    logic             illegal_o;
    logic [CNT_W-1:0] retired_o;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .opcode_i    (opcode_i),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .pc_write_o  (pc_write_o),
        .pc_src_o    (pc_src_o),
        .ir_write_o  (ir_write_o),
        .reg_write_o (reg_write_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .alu_src_a_o (alu_src_a_o),
        .alu_src_b_o (alu_src_b_o),
        .alu_ctrl_o  (alu_ctrl_o),
        .imm_sel_o   (imm_sel_o),
        .wb_sel_o    (wb_sel_o),
        .busy_o      (busy_o),
        .illegal_o   (illegal_o),
        .retired_o   (retired_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       zero;
        int         waitCycles;
        int         expBusy;
        int         expMemRd;
        int         expMemWr;
        int         expRegWr;
        logic       expWbSel;
        logic [3:0] expAlu3;
        logic [1:0] expSrcA3;
        logic [1:0] expSrcB3;
        logic [1:0] expImm3;
        logic       expPcSrc3;
        int         expPcWrites;
        int         expRetire;
        logic       expTrap;
    } vec_t;

    vec_t vecs[$];
    vec_t sbQueue[$];
    int   assertCount = 0;
    int   failCount   = 0;
    int   expRetired  = 0;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;

    function automatic vec_t mkVec(
        input logic [6:0] opcode, input logic [2:0] f3, input logic [6:0] f7,
        input logic zero, input int waitCycles, input int busy, input int memRd,
        input int memWr, input int regWr, input logic wbSel, input logic [3:0] alu3,
        input logic [1:0] srcA3, input logic [1:0] srcB3, input logic [1:0] imm3,
        input logic pcSrc3, input int pcWrites, input int retire, input logic trap);
        vec_t v;
        v.opcode = opcode;   v.f3 = f3;           v.f7 = f7;
        v.zero = zero;       v.waitCycles = waitCycles;
        v.expBusy = busy;    v.expMemRd = memRd;  v.expMemWr = memWr;
        v.expRegWr = regWr;  v.expWbSel = wbSel;  v.expAlu3 = alu3;
        v.expSrcA3 = srcA3;  v.expSrcB3 = srcB3;  v.expImm3 = imm3;
        v.expPcSrc3 = pcSrc3; v.expPcWrites = pcWrites;
        v.expRetire = retire; v.expTrap = trap;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("resetOutputsLow",
            {13'd0, pc_write_o, pc_src_o, ir_write_o, reg_write_o, mem_read_o,
             mem_write_o, alu_src_a_o, alu_src_b_o, alu_ctrl_o, imm_sel_o,
             wb_sel_o, busy_o, illegal_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        expRetired = 0;
        @(negedge clk_i);
        checkOutput("resetRetired", retired_o, 32'd0);
        checkOutput("resetIllegal", {31'd0, illegal_o}, 32'd0);
        checkOutput("resetBusy", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        vec_t e;
        int   cyc = 0, memCnt = 0, memRd = 0, memWr = 0, regWr = 0;
        int   pcWr = 0, irWr = 0;
        logic done = 1'b0;
        logic wbSel = 1'b0, pcSrc3 = 1'b0;
        logic [3:0] alu3 = 4'd0;
        logic [1:0] srcA3 = 2'd0, srcB3 = 2'd0, imm3 = 2'd0;
        logic [5:0] decodePat = 6'd0;
        string tag;
        sbQueue.push_back(v);
        @(negedge clk_i);
        opcode_i    = v.opcode;
        funct3_i    = v.f3;
        funct7_i    = v.f7;
        zero_i      = v.zero;
        mem_ready_i = 1'b1;
        start_i     = 1'b1;
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (!busy_o) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (ir_write_o)  irWr++;
                if (pc_write_o)  pcWr++;
                if (mem_read_o)  memRd++;
                if (mem_write_o) memWr++;
                if (reg_write_o) begin
                    regWr++;
                    wbSel = wb_sel_o;
                end
                if (cyc == 2) decodePat = {alu_src_a_o, alu_src_b_o, imm_sel_o};
                if (cyc == 3) begin
                    alu3 = alu_ctrl_o; srcA3 = alu_src_a_o; srcB3 = alu_src_b_o;
                    imm3 = imm_sel_o;  pcSrc3 = pc_src_o;
                end
                if (mem_read_o || mem_write_o) begin
                    memCnt++;
                    mem_ready_i = (memCnt > v.waitCycles);
                end else begin
                    mem_ready_i = 1'b1;
                end
            end
        end
        tag = $sformatf("v%0d", idx);
        checkOutput({tag, ".finished"}, {31'd0, done}, 32'd1);
        e = sbQueue.pop_front();
        expRetired += e.expRetire;
        checkOutput({tag, ".busyCycles"}, cyc, e.expBusy);
        checkOutput({tag, ".memRdCycles"}, memRd, e.expMemRd);
        checkOutput({tag, ".memWrCycles"}, memWr, e.expMemWr);
        checkOutput({tag, ".regWrCycles"}, regWr, e.expRegWr);
        checkOutput({tag, ".wbSel"}, {31'd0, wbSel}, {31'd0, e.expWbSel});
        checkOutput({tag, ".irWrites"}, irWr, 1);
        checkOutput({tag, ".pcWrites"}, pcWr, e.expPcWrites);
        checkOutput({tag, ".decodeSel"}, {26'd0, decodePat}, 32'h2A);
        checkOutput({tag, ".alu3"}, {28'd0, alu3}, {28'd0, e.expAlu3});
        checkOutput({tag, ".srcA3"}, {30'd0, srcA3}, {30'd0, e.expSrcA3});
        checkOutput({tag, ".srcB3"}, {30'd0, srcB3}, {30'd0, e.expSrcB3});
        checkOutput({tag, ".imm3"}, {30'd0, imm3}, {30'd0, e.expImm3});
        checkOutput({tag, ".pcSrc3"}, {31'd0, pcSrc3}, {31'd0, e.expPcSrc3});
        checkOutput({tag, ".retired"}, retired_o, expRetired);
        checkOutput({tag, ".illegal"}, {31'd0, illegal_o}, {31'd0, e.expTrap});
        if (!done) applyReset();
    endtask

    // TRAP must ignore start and hold the sticky flag until reset.
    task automatic trapHoldAndReset();
        int busyCnt = 0, irCnt = 0;
        start_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (busy_o)     busyCnt++;
            if (ir_write_o) irCnt++;
        end
        start_i = 1'b0;
        checkOutput("trapBusyHeld", busyCnt + irCnt, 0);
        checkOutput("trapIllegalSticky", {31'd0, illegal_o}, 32'd1);
        applyReset();
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; opcode_i = '0; funct3_i = '0;
        funct7_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
        #1;
        checkOutput("initResetBusy", {31'd0, busy_o}, 32'd0);
        checkOutput("initResetStrobes",
            {26'd0, pc_write_o, ir_write_o, reg_write_o, mem_read_o, mem_write_o, illegal_o}, 32'd0);
        applyReset();

        //                 op  f3      f7          z wt  bsy rd wr rw wb alu  A      B      imm    ps pcw ret trap
        vecs.push_back(mkVec(R,  3'b000, 7'b0100000, 0, 0, 4, 0, 0, 1, 0, 4'd1, 2'b01, 2'b00, 2'b00, 0, 1, 1, 0));
        vecs.push_back(mkVec(R,  3'b000, 7'b0000000, 0, 0, 4, 0, 0, 1, 0, 4'd0, 2'b01, 2'b00, 2'b00, 0, 1, 1, 0));
        vecs.push_back(mkVec(R,  3'b111, 7'b0000000, 0, 0, 4, 0, 0, 1, 0, 4'd2, 2'b01, 2'b00, 2'b00, 0, 1, 1, 0));
        vecs.push_back(mkVec(R,  3'b110, 7'b0000000, 0, 0, 4, 0, 0, 1, 0, 4'd3, 2'b01, 2'b00, 2'b00, 0, 1, 1, 0));
        vecs.push_back(mkVec(R,  3'b100, 7'b0000000, 0, 0, 4, 0, 0, 1, 0, 4'd4, 2'b01, 2'b00, 2'b00, 0, 1, 1, 0));
        vecs.push_back(mkVec(R,  3'b001, 7'b0000000, 0, 0, 4, 0, 0, 1, 0, 4'd5, 2'b01, 2'b00, 2'b00, 0, 1, 1, 0));
        vecs.push_back(mkVec(R,  3'b000, 7'b0000001, 0, 0, 4, 0, 0, 1, 0, 4'd7, 2'b01, 2'b00, 2'b00, 0, 1, 1, 0));
        vecs.push_back(mkVec(I,  3'b000, 7'b0000000, 0, 0, 4, 0, 0, 1, 0, 4'd0, 2'b01, 2'b10, 2'b00, 0, 1, 1, 0));
        vecs.push_back(mkVec(I,  3'b101, 7'b0100000, 0, 0, 4, 0, 0, 1, 0, 4'd6, 2'b01, 2'b10, 2'b00, 0, 1, 1, 0));
        vecs.push_back(mkVec(LD, 3'b010, 7'b0000000, 0, 0, 5, 1, 0, 1, 1, 4'd0, 2'b01, 2'b10, 2'b00, 0, 1, 1, 0));
        vecs.push_back(mkVec(LD, 3'b010, 7'b0000000, 0, 3, 8, 4, 0, 1, 1, 4'd0, 2'b01, 2'b10, 2'b00, 0, 1, 1, 0));
        vecs.push_back(mkVec(ST, 3'b010, 7'b0000000, 0, 0, 4, 0, 1, 0, 0, 4'd0, 2'b01, 2'b10, 2'b01, 0, 1, 1, 0));
        vecs.push_back(mkVec(ST, 3'b010, 7'b0000000, 0, 2, 6, 0, 3, 0, 0, 4'd0, 2'b01, 2'b10, 2'b01, 0, 1, 1, 0));
        vecs.push_back(mkVec(BR, 3'b000, 7'b0000000, 1, 0, 3, 0, 0, 0, 0, 4'd1, 2'b01, 2'b00, 2'b00, 1, 2, 1, 0));
        vecs.push_back(mkVec(BR, 3'b000, 7'b0000000, 0, 0, 3, 0, 0, 0, 0, 4'd1, 2'b01, 2'b00, 2'b00, 1, 1, 1, 0));
        vecs.push_back(mkVec(7'b1101111, 3'b000, 7'b0, 0, 0, 2, 0, 0, 0, 0, 4'd0, 2'b00, 2'b00, 2'b00, 0, 1, 0, 1));
        vecs.push_back(mkVec(R,  3'b010, 7'b0000000, 0, 0, 3, 0, 0, 0, 0, 4'd0, 2'b01, 2'b00, 2'b00, 0, 1, 0, 1));
        vecs.push_back(mkVec(I,  3'b001, 7'b0000000, 0, 0, 3, 0, 0, 0, 0, 4'd0, 2'b01, 2'b10, 2'b00, 0, 1, 0, 1));
        vecs.push_back(mkVec(LD, 3'b000, 7'b0000000, 0, 0, 3, 0, 0, 0, 0, 4'd0, 2'b01, 2'b10, 2'b00, 0, 1, 0, 1));
        vecs.push_back(mkVec(ST, 3'b000, 7'b0000000, 0, 0, 3, 0, 0, 0, 0, 4'd0, 2'b01, 2'b10, 2'b01, 0, 1, 0, 1));
        vecs.push_back(mkVec(BR, 3'b001, 7'b0000000, 0, 0, 3, 0, 0, 0, 0, 4'd1, 2'b01, 2'b00, 2'b00, 1, 1, 0, 1));
        vecs.push_back(mkVec(R,  3'b111, 7'b0000000, 0, 0, 4, 0, 0, 1, 0, 4'd2, 2'b01, 2'b00, 2'b00, 0, 1, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
            if (vecs[i].expTrap) trapHoldAndReset();
        end

        // Back-to-back addi with start held, then start dropped in EXEC_I.
        $display("[TB] back-to-back addi, start dropped mid-instruction");
        @(negedge clk_i);
        opcode_i = I; funct3_i = 3'b000; funct7_i = 7'b0; mem_ready_i = 1'b1; start_i = 1'b1;
        repeat (5) @(negedge clk_i);
        checkOutput("chainFetchIrWrite", {31'd0, ir_write_o}, 32'd1);
        checkOutput("chainRetiredFirst", retired_o, expRetired + 1);
        repeat (2) @(negedge clk_i);
        checkOutput("chainExecISrcB", {30'd0, alu_src_b_o}, 32'd2);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("chainIdleAfterDrop", {31'd0, busy_o}, 32'd0);
        checkOutput("chainRetiredSecond", retired_o, expRetired + 2);
        expRetired += 2;

        // Reset arriving during a load's memory wait.
        $display("[TB] reset during memory wait");
        @(negedge clk_i);
        opcode_i = LD; funct3_i = 3'b010; mem_ready_i = 1'b0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("waitMemRead", {31'd0, mem_read_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("rstDropsMemRead", {31'd0, mem_read_o}, 32'd0);
        checkOutput("rstBusyLow", {31'd0, busy_o}, 32'd0);
        checkOutput("rstRetiredZero", retired_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("postRstIdle", {30'd0, busy_o, mem_read_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
